// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: writes a deterministic pattern over words 0..DEPTH-1,
// then reads them back with optional pacing and checks every returned word in
// request order, counting mismatches and capturing the first failing address.
// Optional build macro SDRAM_TESTER_LFSR_EN selects a Galois LFSR pattern
// instead of the default (address + SEED) incrementing pattern.
module sdram_pattern_tester #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 24,
  parameter int          DEPTH    = 256,
  parameter int          READ_GAP = 0,
  parameter int unsigned SEED     = 0,
  parameter int          ERR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  output logic              write_enable,
  output logic [DATA_W-1:0] write_data,
  output logic              read_enable,
  input  logic              wait_request,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_fail_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Gap counter needs at least one bit even when pacing is disabled.
  localparam int GAP_W = (READ_GAP > 0) ? $clog2(READ_GAP + 1) : 1;

  // One extra address bit so a window of exactly 2**ADDR_W words still ends.
  localparam logic [ADDR_W:0]  LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  ADDR_ONE  = (ADDR_W + 1)'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(READ_GAP);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [DATA_W-1:0] SEED_VAL = DATA_W'(SEED);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W:0]   addr_reg, addr_next;
  logic [ADDR_W:0]   rc_reg, rc_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic [ERR_W-1:0]  err_reg, err_next;
  logic [ADDR_W-1:0] ff_reg, ff_next;

  logic              start_pass;
  logic              wr_acc;
  logic              rd_acc;
  logic              check_en;
  logic [DATA_W-1:0] wr_pat;
  logic [DATA_W-1:0] chk_pat;

  assign start_pass = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign wr_acc     = write_enable && !wait_request;
  assign rd_acc     = read_enable && !wait_request;
  assign check_en   = read_valid && ((state_reg == S_READ) || (state_reg == S_DRAIN));

`ifdef SDRAM_TESTER_LFSR_EN
  // Right-shifting Galois LFSR; tap masks hold bit (k-1) for each term x^k.
  function automatic logic [DATA_W-1:0] lfsr_taps();
    logic [DATA_W-1:0] t;
    t = '0;
    case (DATA_W)
      8:       t = DATA_W'(32'h0000_00B8);
      16:      t = DATA_W'(32'h0000_B400);
      32:      t = DATA_W'(32'h8020_0003);
      default: t = '0;
    endcase
    return t;
  endfunction

  localparam logic [DATA_W-1:0] LFSR_TAPS = lfsr_taps();
  localparam logic [DATA_W-1:0] LFSR_INIT = (SEED_VAL == '0) ? DATA_W'(1) : SEED_VAL;

  if ((DATA_W != 8) && (DATA_W != 16) && (DATA_W != 32)) begin : g_bad_lfsr_width
    $error("sdram_pattern_tester: LFSR pattern supports DATA_W of 8, 16 or 32 only");
  end

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
    return {1'b0, v[DATA_W-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  logic [DATA_W-1:0] wr_lfsr_reg;
  logic [DATA_W-1:0] chk_lfsr_reg;

  // Writer and checker LFSRs reload together at pass start and step independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_lfsr_reg  <= '0;
      chk_lfsr_reg <= '0;
    end else if (start_pass) begin
      wr_lfsr_reg  <= LFSR_INIT;
      chk_lfsr_reg <= LFSR_INIT;
    end else begin
      if (wr_acc)   wr_lfsr_reg  <= lfsr_step(wr_lfsr_reg);
      if (check_en) chk_lfsr_reg <= lfsr_step(chk_lfsr_reg);
    end
  end

  assign wr_pat  = wr_lfsr_reg;
  assign chk_pat = chk_lfsr_reg;
`else
  // Incrementing pattern: the word's own index plus the seed, wrapping at DATA_W.
  assign wr_pat  = DATA_W'(addr_reg) + SEED_VAL;
  assign chk_pat = DATA_W'(rc_reg) + SEED_VAL;
`endif

  // Next-state logic for the sequencer, the return counter and error capture.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rc_next    = rc_reg;
    gap_next   = gap_reg;
    err_next   = err_reg;
    ff_next    = ff_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_WRITE;
          addr_next  = '0;
          rc_next    = '0;
          gap_next   = '0;
          err_next   = '0;
          ff_next    = '0;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          if (addr_reg == LAST_ADDR) begin
            state_next = S_READ;
            addr_next  = '0;
          end else begin
            addr_next = addr_reg + ADDR_ONE;
          end
        end
      end
      S_READ: begin
        if (gap_reg != '0) begin
          gap_next = gap_reg - GAP_W'(1);
        end
        if (rd_acc) begin
          gap_next = GAP_LOAD;
          if (addr_reg == LAST_ADDR) begin
            state_next = S_DRAIN;
          end else begin
            addr_next = addr_reg + ADDR_ONE;
          end
        end
      end
      S_DRAIN: begin
        state_next = S_DRAIN;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Returned words arrive in request order, so rc names the word being checked.
    if (check_en) begin
      rc_next = rc_reg + ADDR_ONE;
      if (read_data != chk_pat) begin
        if (err_reg == '0) begin
          ff_next = rc_reg[ADDR_W-1:0];
        end
        if (err_reg != ERR_MAX) begin
          err_next = err_reg + ERR_W'(1);
        end
      end
    end

    if ((state_reg == S_DRAIN) && (rc_next == DEPTH_CNT)) begin
      state_next = S_DONE;
    end
  end

  // State registers; reset aborts any pass in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      rc_reg    <= '0;
      gap_reg   <= '0;
      err_reg   <= '0;
      ff_reg    <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rc_reg    <= rc_next;
      gap_reg   <= gap_next;
      err_reg   <= err_next;
      ff_reg    <= ff_next;
    end
  end

  assign address         = addr_reg[ADDR_W-1:0];
  assign write_enable    = (state_reg == S_WRITE);
  assign write_data      = (state_reg == S_WRITE) ? wr_pat : '0;
  assign read_enable     = (state_reg == S_READ) && (gap_reg == '0);
  assign busy            = (state_reg == S_WRITE) || (state_reg == S_READ) || (state_reg == S_DRAIN);
  assign done            = (state_reg == S_DONE);
  assign pass            = (state_reg == S_DONE) && (err_reg == '0);
  assign error_count     = err_reg;
  assign first_fail_addr = ff_reg;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: two instances share one clock.
// Channel 0: DEPTH=8, DATA_W=8, SEED=0x10, back-to-back reads, 16-bit error count.
// Channel 1: full 3-bit address window (DEPTH=2**ADDR_W), READ_GAP=3, 2-bit error count.
// Each channel has a latency-2 memory model that can corrupt chosen addresses.
module tb_sdram_pattern_tester;

  localparam int unsigned SEED_V = 32'h10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] wait_request = '0;
  logic [1:0] write_enable, read_enable, busy, done, pass;
  logic [1:0] read_valid = '0;
  logic [1:0] pend_v = '0;
  logic [7:0] address [2];
  logic [7:0] write_data [2];
  logic [7:0] read_data [2];
  logic [7:0] pend_d [2];
  logic [15:0] error_count [2];
  logic [7:0] first_fail_addr [2];
  logic [7:0] corrupt [2];
  logic [7:0] mem [2][256];

  logic [2:0] addr_b, ffa_b;
  logic [1:0] ec_b;

  int total = 0;
  int bad = 0;

  assign address[1]         = {5'b0, addr_b};
  assign first_fail_addr[1] = {5'b0, ffa_b};
  assign error_count[1]     = {14'b0, ec_b};

  sdram_pattern_tester #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(8), .READ_GAP(0), .SEED(SEED_V), .ERR_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .address(address[0]),
    .write_enable(write_enable[0]), .write_data(write_data[0]),
    .read_enable(read_enable[0]), .wait_request(wait_request[0]),
    .read_data(read_data[0]), .read_valid(read_valid[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .error_count(error_count[0]), .first_fail_addr(first_fail_addr[0])
  );

  sdram_pattern_tester #(
    .DATA_W(8), .ADDR_W(3), .DEPTH(8), .READ_GAP(3), .SEED(SEED_V), .ERR_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .address(addr_b),
    .write_enable(write_enable[1]), .write_data(write_data[1]),
    .read_enable(read_enable[1]), .wait_request(wait_request[1]),
    .read_data(read_data[1]), .read_valid(read_valid[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .error_count(ec_b), .first_fail_addr(ffa_b)
  );

  // Memory models: fixed read latency of 2 cycles, in order, optional corruption.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (write_enable[c] && !wait_request[c]) mem[c][address[c]] <= write_data[c];
      read_valid[c] <= pend_v[c];
      read_data[c]  <= pend_d[c];
      pend_v[c]     <= read_enable[c] && !wait_request[c];
      pend_d[c]     <= corrupt[c][address[c][2:0]] ? 8'hFF : mem[c][address[c]];
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      total++; if (address[c] !== 8'h00) begin bad++; $display("FAIL reset_address ch=%0d got=%0h want=0", c, address[c]); end
      total++; if (write_data[c] !== 8'h00) begin bad++; $display("FAIL reset_wdata ch=%0d got=%0h want=0", c, write_data[c]); end
      total++; if ({write_enable[c], read_enable[c]} !== 2'b00) begin bad++; $display("FAIL reset_enables ch=%0d got=%b want=00", c, {write_enable[c], read_enable[c]}); end
      total++; if ({busy[c], done[c], pass[c]} !== 3'b000) begin bad++; $display("FAIL reset_status ch=%0d got=%b want=000", c, {busy[c], done[c], pass[c]}); end
      total++; if (error_count[c] !== 16'h0) begin bad++; $display("FAIL reset_errcnt ch=%0d got=%0d want=0", c, error_count[c]); end
      total++; if (first_fail_addr[c] !== 8'h00) begin bad++; $display("FAIL reset_ffaddr ch=%0d got=%0h want=0", c, first_fail_addr[c]); end
    end
    reset = 1'b0;
    @(negedge clk);
    $display("reset: outputs checked on both channels");
  endtask

  // One full pass on a channel, observed cycle by cycle against the expected
  // write sequence, read sequence and pacing; final status from the mask.
  task automatic run_pass(input int ch, input int wait_pct, input logic [7:0] cmask,
                          input int stall_wa, input int stall_ra, input bit start_noise,
                          input string tag);
    int gap, errmax, exp_err, exp_ff, wi, ri, cyc, last_w, last_r, stall_w, stall_r;
    bit found, fin, tight, w;
    logic [7:0] exp_d;
    gap = (ch == 1) ? 3 : 0;
    errmax = (ch == 1) ? 3 : 65535;
    exp_err = 0; exp_ff = 0; found = 0;
    for (int a = 0; a < 8; a++) begin
      exp_d = 8'((a + SEED_V) % 256);
      if (cmask[a] && exp_d != 8'hFF) begin
        exp_err++;
        if (!found) begin exp_ff = a; found = 1; end
      end
    end
    if (exp_err > errmax) exp_err = errmax;
    tight = (wait_pct == 0) && (stall_wa < 0) && (stall_ra < 0);
    wi = 0; ri = 0; cyc = 0; last_w = -1; last_r = -100; stall_w = 3; stall_r = 3; fin = 0;
    corrupt[ch] = cmask;
    @(negedge clk); start[ch] = 1'b1;
    @(negedge clk); start[ch] = 1'b0;
    while (!fin && cyc < 500) begin
      if (done[ch]) begin
        fin = 1;
        start[ch] = 1'b0;
        wait_request[ch] = 1'b0;
      end else begin
        w = ($urandom_range(0, 99) < wait_pct);
        if (write_enable[ch] && int'(address[ch]) == stall_wa && stall_w > 0) begin w = 1; stall_w--; end
        if (read_enable[ch] && int'(address[ch]) == stall_ra && stall_r > 0) begin w = 1; stall_r--; end
        wait_request[ch] = w;
        start[ch] = start_noise && ($urandom_range(0, 7) == 0);
        total++; if (busy[ch] !== 1'b1) begin bad++; $display("FAIL %s busy ch=%0d cyc=%0d got=%b want=1", tag, ch, cyc, busy[ch]); end
        if (cyc == 0) begin
          total++; if (write_enable[ch] !== 1'b1) begin bad++; $display("FAIL %s first_write ch=%0d got=%b want=1", tag, ch, write_enable[ch]); end
        end
        if (write_enable[ch]) begin
          exp_d = 8'((wi + SEED_V) % 256);
          total++; if (address[ch] !== 8'(wi)) begin bad++; $display("FAIL %s wr_addr ch=%0d cyc=%0d got=%0d want=%0d", tag, ch, cyc, address[ch], wi); end
          total++; if (write_data[ch] !== exp_d) begin bad++; $display("FAIL %s wr_data ch=%0d cyc=%0d got=%0h want=%0h", tag, ch, cyc, write_data[ch], exp_d); end
          if (!w) begin
            if (tight && last_w >= 0) begin
              total++; if (cyc != last_w + 1) begin bad++; $display("FAIL %s wr_spacing ch=%0d got=%0d want=1", tag, ch, cyc - last_w); end
            end
            last_w = cyc; wi++;
          end
        end
        if (read_enable[ch]) begin
          total++; if (write_enable[ch] !== 1'b0 || wi != 8) begin bad++; $display("FAIL %s rd_early ch=%0d writes=%0d want=8", tag, ch, wi); end
          total++; if (cyc - last_r <= gap) begin bad++; $display("FAIL %s rd_gap ch=%0d got=%0d want>%0d", tag, ch, cyc - last_r, gap); end
          total++; if (address[ch] !== 8'(ri)) begin bad++; $display("FAIL %s rd_addr ch=%0d cyc=%0d got=%0d want=%0d", tag, ch, cyc, address[ch], ri); end
          if (!w) begin
            if (tight && ri > 0) begin
              total++; if (cyc - last_r != gap + 1) begin bad++; $display("FAIL %s rd_spacing ch=%0d got=%0d want=%0d", tag, ch, cyc - last_r, gap + 1); end
            end
            last_r = cyc; ri++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    start[ch] = 1'b0;
    wait_request[ch] = 1'b0;
    total++; if (!fin) begin bad++; $display("FAIL %s timeout ch=%0d got=no_done want=done", tag, ch); end
    total++; if (wi != 8 || ri != 8) begin bad++; $display("FAIL %s counts ch=%0d got=w%0d/r%0d want=w8/r8", tag, ch, wi, ri); end
    total++; if (error_count[ch] !== 16'(exp_err)) begin bad++; $display("FAIL %s errcnt ch=%0d got=%0d want=%0d", tag, ch, error_count[ch], exp_err); end
    total++; if (first_fail_addr[ch] !== 8'(exp_ff)) begin bad++; $display("FAIL %s ffaddr ch=%0d got=%0d want=%0d", tag, ch, first_fail_addr[ch], exp_ff); end
    total++; if (pass[ch] !== (exp_err == 0)) begin bad++; $display("FAIL %s pass ch=%0d got=%b want=%b", tag, ch, pass[ch], exp_err == 0); end
    total++; if (busy[ch] !== 1'b0) begin bad++; $display("FAIL %s busy_end ch=%0d got=%b want=0", tag, ch, busy[ch]); end
    if (tight && ch == 1) begin
      total++; if (last_r - (last_w + 1) + 1 != 8 + 3 * 7) begin bad++; $display("FAIL %s rd_phase ch=%0d got=%0d want=29", tag, ch, last_r - last_w); end
    end
    repeat (2) @(negedge clk);
    total++; if (done[ch] !== 1'b1) begin bad++; $display("FAIL %s done_hold ch=%0d got=%b want=1", tag, ch, done[ch]); end
    $display("%s ch=%0d mask=%02h wait=%0d%% cycles=%0d errs=%0d ff=%0d pass=%b",
             tag, ch, cmask, wait_pct, cyc, error_count[ch], first_fail_addr[ch], pass[ch]);
  endtask

  task automatic test_reset_midread();
    int n;
    corrupt[0] = 8'h03;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    n = 0;
    while (!(read_enable[0] && address[0] == 8'd3) && n < 100) begin
      @(negedge clk); n++;
    end
    total++; if (n >= 100) begin bad++; $display("FAIL midread_reach got=timeout want=read_addr3"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({write_enable[0], read_enable[0], busy[0], done[0]} !== 4'b0000) begin bad++; $display("FAIL midread_ctrl got=%b want=0000", {write_enable[0], read_enable[0], busy[0], done[0]}); end
    total++; if (address[0] !== 8'h00 || error_count[0] !== 16'h0 || first_fail_addr[0] !== 8'h00) begin bad++; $display("FAIL midread_regs got=a%0d/e%0d/f%0d want=0/0/0", address[0], error_count[0], first_fail_addr[0]); end
    @(negedge clk);
    total++; if (busy[0] !== 1'b0 || error_count[0] !== 16'h0) begin bad++; $display("FAIL midread_stale got=b%b/e%0d want=0/0", busy[0], error_count[0]); end
    $display("midread reset: aborted at read 3");
    run_pass(0, 0, 8'h00, -1, -1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_pass(i % 2, $urandom_range(0, 40), 8'($urandom), -1, -1, 1'b1, "random");
    end
  endtask

  initial begin
    corrupt[0] = '0;
    corrupt[1] = '0;
    test_reset();
    run_pass(0, 0, 8'h00, -1, -1, 1'b0, "basic");
    run_pass(0, 0, 8'h20, -1, -1, 1'b0, "corrupt5");
    run_pass(0, 0, 8'h00, 2, 4, 1'b0, "stalls");
    run_pass(1, 0, 8'h00, -1, -1, 1'b0, "read_gap");
    run_pass(1, 0, 8'hFF, -1, -1, 1'b0, "saturate");
    run_pass(1, 0, 8'h00, 2, 4, 1'b0, "gap_stalls");
    test_reset_midread();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
